// File: rtl/bdram_port_master.sv
// rtl/bdram_port_master.sv - load/store unit to single-port block RAM initiator bridge
//
// Purpose: accepts one byte/half/word load or store per handshake, drives the
// RAM port combinationally in the accept cycle, captures the RAM's registered
// read word one cycle later and returns a held, lane-extracted response.
// Misaligned or illegal-size requests are flagged and never written.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_*_i/req_ready_o request handshake (we, size, unsigned, addr, wdata)
//   resp_*_o/resp_ready_i response handshake (rdata, err), held until consumed
//   ram_*_o, ram_rdata_i RAM port (enable, byte write enables, word addr, data)

module bdram_port_master #(
  parameter int ADDR_W = 17
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              uns_q;
  logic              err_q;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              accept;
  logic              req_err;
  logic [3:0]        mask;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;

  // Byte-address bits above the RAM window are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:ADDR_W+2];

  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;

  assign req_err = (req_size_i == 2'd3)
                 | ((req_size_i == 2'd1) && req_addr_i[0])
                 | ((req_size_i == 2'd2) && (req_addr_i[1:0] != 2'b00));

  always_comb begin
    mask        = 4'b0000;
    ram_wdata_o = req_wdata_i;
    case (req_size_i)
      2'd0: begin
        mask        = 4'b0001 << req_addr_i[1:0];
        ram_wdata_o = {4{req_wdata_i[7:0]}};
      end
      2'd1: begin
        mask        = 4'b0011 << req_addr_i[1:0];
        ram_wdata_o = {2{req_wdata_i[15:0]}};
      end
      2'd2: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
  end

  assign ram_en_o = accept;
  assign ram_we_o = (accept && req_we_i && !req_err) ? mask : 4'b0000;
  // Once a request is in flight the registered word address keeps ram_rdata stable.
  assign ram_addr_o = (state_q == IDLE) ? req_addr_i[ADDR_W+1:2] : addr_q;

  assign byte_lane = 8'(ram_rdata_i >> {off_q, 3'b000});
  assign half_lane = off_q[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];

  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = CAPT;
      end
      CAPT: begin
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        resp_rdata_d = 32'h0;
        if (!we_q && !err_q) begin
          case (size_q)
            2'd0:    resp_rdata_d = uns_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            2'd1:    resp_rdata_d = uns_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: resp_rdata_d = ram_rdata_i;
          endcase
        end
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      off_q  <= 2'b00;
      size_q <= 2'b00;
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      addr_q <= req_addr_i[ADDR_W+1:2];
      off_q  <= req_addr_i[1:0];
      size_q <= req_size_i;
      we_q   <= req_we_i;
      uns_q  <= req_unsigned_i;
      err_q  <= req_err;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_bdram_port_master.sv
// tb/tb_bdram_port_master.sv - directed self-checking bench for bdram_port_master

module tb_bdram_port_master;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_ready, resp_err;
  logic [31:0]       resp_rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  logic [31:0] mem [0:255];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bdram_port_master #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // Block RAM model: byte-enabled write, read data registered every cycle (read-old).
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr[7:0]];
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction with resp_ready high: accept at E0, response after E1, consumed at E2.
  task automatic xact(input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] exp_we, input logic [31:0] exp_wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; resp_ready = 1'b1;
    #1;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".ram_en"}, 32'(ram_en), 32'd1);
    chk({tag, ".ram_we"}, 32'(ram_we), 32'(exp_we));
    chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(addr[ADDR_W+1:2]));
    if (we) chk({tag, ".ram_wdata"}, ram_wdata, exp_wd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, ".valid_e0"}, 32'(resp_valid), 32'd0);
    chk({tag, ".ready_e0"}, 32'(req_ready), 32'd0);
    chk({tag, ".we_e0"}, 32'(ram_we), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".valid_e1"}, 32'(resp_valid), 32'd1);
    chk({tag, ".rdata"}, resp_rdata, exp_rd);
    chk({tag, ".err"}, 32'(resp_err), 32'(exp_err));
    @(posedge clk); #1;
    chk({tag, ".valid_e2"}, 32'(resp_valid), 32'd0);
    chk({tag, ".ready_e2"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h1; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.ram_en", 32'(ram_en), 32'd0);
    chk("rst.ram_we", 32'(ram_we), 32'd0);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst.req_ready", 32'(req_ready), 32'd1);
    chk("post_rst.mem_untouched", mem[4], 32'h0);

    xact("sw10",  1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("lw10",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("sb13",  1'b1, 2'd0, 1'b0, 32'h13, 32'h12345680, 4'b1000, 32'h80808080, 32'h0, 1'b0);
    xact("lb13",  1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0);
    xact("lbu13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 4'b0000, 32'h0, 32'h00000080, 1'b0);
    xact("lb11",  1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 4'b0000, 32'h0, 32'hFFFFFFBE, 1'b0);
    xact("lbu12", 1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 4'b0000, 32'h0, 32'h000000AD, 1'b0);
    xact("sh16",  1'b1, 2'd1, 1'b0, 32'h16, 32'h00001234, 4'b1100, 32'h12341234, 32'h0, 1'b0);
    xact("lh16",  1'b0, 2'd1, 1'b0, 32'h16, 32'h0, 4'b0000, 32'h0, 32'h00001234, 1'b0);
    xact("sh14",  1'b1, 2'd1, 1'b0, 32'h14, 32'hFFFF8001, 4'b0011, 32'h80018001, 32'h0, 1'b0);
    xact("lhu14", 1'b0, 2'd1, 1'b1, 32'h14, 32'h0, 4'b0000, 32'h0, 32'h00008001, 1'b0);
    xact("lh14",  1'b0, 2'd1, 1'b0, 32'h14, 32'h0, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0);
    xact("lw12",  1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
    xact("sh11",  1'b1, 2'd1, 1'b0, 32'h11, 32'h0000FFFF, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("sz3",   1'b1, 2'd3, 1'b0, 32'h10, 32'h00000000, 4'b0000, 32'h00000000, 32'h0, 1'b1);
    xact("rb10",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4'b0000, 32'h0, 32'h80ADBEEF, 1'b0);
    xact("rb14",  1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 4'b0000, 32'h0, 32'h12348001, 1'b0);

    // Backpressure: response held for 5 cycles, a competing store is never accepted.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", 32'(resp_valid), 32'd1);
      chk("bp.rdata", resp_rdata, 32'h80ADBEEF);
      chk("bp.req_ready", 32'(req_ready), 32'd0);
      chk("bp.ram_addr", 32'(ram_addr), 32'h4);
      chk("bp.ram_we", 32'(ram_we), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.consumed", 32'(resp_valid), 32'd0);
    chk("bp.no_write", mem[8], 32'h0);

    // Reset while a response is pending.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h14; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rr.valid_before", 32'(resp_valid), 32'd1);
    rst = 1'b1; req_valid = 1'b1;
    #1;
    chk("rr.valid_async", 32'(resp_valid), 32'd0);
    chk("rr.ready_in_rst", 32'(req_ready), 32'd0);
    chk("rr.en_in_rst", 32'(ram_en), 32'd0);
    @(posedge clk); #1;
    chk("rr.rdata_clr", resp_rdata, 32'h0);
    req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rr.ready_after", 32'(req_ready), 32'd1);
    chk("rr.valid_after", 32'(resp_valid), 32'd0);
    xact("rr.lw14", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 4'b0000, 32'h0, 32'h12348001, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
